// File: rtl/iq_rotator_pipe.sv
// Three-stage pipelined complex rotator: register, multiply, sum/round/saturate.
// Define ROT_SAT_COUNT_EN to build in the saturating clip-event counter on o_satCount.
module iq_rotator_pipe #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FRAC_BITS     = 7,
  parameter int unsigned SAT_CNT_WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    i_dataI,
  input  logic [DATA_WIDTH-1:0]    i_dataQ,
  input  logic [DATA_WIDTH-1:0]    i_dataSin,
  input  logic [DATA_WIDTH-1:0]    i_dataCos,
  input  logic                     i_conj,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_dataRotatedI,
  output logic [DATA_WIDTH-1:0]    o_dataRotatedQ,
  output logic                     o_sat,
  output logic [SAT_CNT_WIDTH-1:0] o_satCount
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned SW = PW + 1;
  localparam logic signed [SW-1:0] RND     = SW'(1 << (FRAC_BITS - 1));
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DATA_WIDTH-1:0] s1_i, s1_q, s1_sin, s1_cos;
  logic                         s1_conj, s1_valid;
  logic signed [PW-1:0]         p_icos, p_qsin, p_isin, p_qcos;
  logic                         s2_conj, s2_valid;

  logic signed [SW-1:0] e_icos, e_qsin, e_isin, e_qcos;
  logic signed [SW-1:0] sum_i, sum_q, rnd_i, rnd_q, sh_i, sh_q;
  logic                 hi_i, lo_i, hi_q, lo_q;
  logic [DATA_WIDTH-1:0] res_i, res_q;
  logic                  sat_d;

  assign e_icos = {p_icos[PW-1], p_icos};
  assign e_qsin = {p_qsin[PW-1], p_qsin};
  assign e_isin = {p_isin[PW-1], p_isin};
  assign e_qcos = {p_qcos[PW-1], p_qcos};

  always_comb begin
    sum_i = '0;
    sum_q = '0;
    if (s2_conj) begin
      sum_i = e_icos + e_qsin;
      sum_q = e_qcos - e_isin;
    end else begin
      sum_i = e_icos - e_qsin;
      sum_q = e_isin + e_qcos;
    end
    // Round half up, then arithmetic shift back to integer scale.
    rnd_i = sum_i + RND;
    rnd_q = sum_q + RND;
    sh_i  = rnd_i >>> FRAC_BITS;
    sh_q  = rnd_q >>> FRAC_BITS;
    hi_i  = sh_i > SAT_MAX;
    lo_i  = sh_i < SAT_MIN;
    hi_q  = sh_q > SAT_MAX;
    lo_q  = sh_q < SAT_MIN;
    res_i = hi_i ? SAT_MAX[DATA_WIDTH-1:0] : lo_i ? SAT_MIN[DATA_WIDTH-1:0] : sh_i[DATA_WIDTH-1:0];
    res_q = hi_q ? SAT_MAX[DATA_WIDTH-1:0] : lo_q ? SAT_MIN[DATA_WIDTH-1:0] : sh_q[DATA_WIDTH-1:0];
    sat_d = s2_valid & (hi_i | lo_i | hi_q | lo_q);
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      s1_i           <= '0;
      s1_q           <= '0;
      s1_sin         <= '0;
      s1_cos         <= '0;
      s1_conj        <= 1'b0;
      s1_valid       <= 1'b0;
      p_icos         <= '0;
      p_qsin         <= '0;
      p_isin         <= '0;
      p_qcos         <= '0;
      s2_conj        <= 1'b0;
      s2_valid       <= 1'b0;
      o_valid        <= 1'b0;
      o_dataRotatedI <= '0;
      o_dataRotatedQ <= '0;
      o_sat          <= 1'b0;
    end else if (i_enable) begin
      s1_i           <= i_dataI;
      s1_q           <= i_dataQ;
      s1_sin         <= i_dataSin;
      s1_cos         <= i_dataCos;
      s1_conj        <= i_conj;
      s1_valid       <= i_valid;
      p_icos         <= s1_i * s1_cos;
      p_qsin         <= s1_q * s1_sin;
      p_isin         <= s1_i * s1_sin;
      p_qcos         <= s1_q * s1_cos;
      s2_conj        <= s1_conj;
      s2_valid       <= s1_valid;
      o_valid        <= s2_valid;
      o_dataRotatedI <= res_i;
      o_dataRotatedQ <= res_q;
      o_sat          <= sat_d;
    end
  end

`ifdef ROT_SAT_COUNT_EN
  logic [SAT_CNT_WIDTH-1:0] sat_cnt_q;

  // Counts alongside o_sat rising for that sample; sticks at all-ones.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sat_cnt_q <= '0;
    end else if (i_enable && sat_d && (sat_cnt_q != '1)) begin
      sat_cnt_q <= sat_cnt_q + SAT_CNT_WIDTH'(1);
    end
  end

  assign o_satCount = sat_cnt_q;
`else
  assign o_satCount = '0;
`endif

endmodule

// File: tb/tb_iq_rotator_pipe.sv
// Bench for iq_rotator_pipe: arithmetic reference model with a latency queue,
// a per-cycle compare process, and directed literal vectors.
module tb_iq_rotator_pipe;

  localparam int DW = 8;
  localparam int FB = 7;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          i_reset, i_enable, i_valid, i_conj;
  logic [DW-1:0] i_dataI, i_dataQ, i_dataSin, i_dataCos;
  logic          o_valid, o_sat;
  logic [DW-1:0] o_dataRotatedI, o_dataRotatedQ;
  logic [CW-1:0] o_satCount;

  iq_rotator_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .SAT_CNT_WIDTH(CW)) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_valid        (i_valid),
    .i_dataI        (i_dataI),
    .i_dataQ        (i_dataQ),
    .i_dataSin      (i_dataSin),
    .i_dataCos      (i_dataCos),
    .i_conj         (i_conj),
    .o_valid        (o_valid),
    .o_dataRotatedI (o_dataRotatedI),
    .o_dataRotatedQ (o_dataRotatedQ),
    .o_sat          (o_sat),
    .o_satCount     (o_satCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    int ri;
    int rq;
    bit sat;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   en_cnt   = 0;
  int   last_kind = 0;  // 0 none, 1 reset edge, 2 enabled edge, 3 stalled edge
  int   model_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int clamp(input int v, output bit clipped);
    int hi = (1 << (DW - 1)) - 1;
    int lo = -(1 << (DW - 1));
    clipped = (v > hi) || (v < lo);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  // Plain complex multiply by (cos +/- j sin), round half up, clamp.
  function automatic exp_t rot(input int i, input int q, input int s, input int c, input bit conj);
    exp_t e;
    int   ip, qp;
    bit   ci, cq;
    ip = conj ? (i * c + q * s) : (i * c - q * s);
    qp = conj ? (q * c - i * s) : (i * s + q * c);
    e.ri  = clamp((ip + (1 << (FB - 1))) >>> FB, ci);
    e.rq  = clamp((qp + (1 << (FB - 1))) >>> FB, cq);
    e.sat = ci | cq;
    e.due = 0;
    return e;
  endfunction

  always @(posedge clock) begin
    if (i_reset) begin
      exp_q.delete();
      last_kind = 1;
    end else if (i_enable) begin
      en_cnt++;
      if (i_valid) begin
        exp_t e;
        e = rot(int'($signed(i_dataI)), int'($signed(i_dataQ)), int'($signed(i_dataSin)),
                int'($signed(i_dataCos)), i_conj);
        e.due = en_cnt + 2;
        exp_q.push_back(e);
      end
      last_kind = 2;
    end else begin
      last_kind = 3;
    end
  end

  logic          pv_valid, pv_sat;
  logic [DW-1:0] pv_i, pv_q;
  logic [CW-1:0] pv_cnt;

  always @(negedge clock) begin
    if (last_kind == 1) begin
      model_cnt = 0;
      chk("reset_valid", int'(o_valid), 0);
      chk("reset_i", int'(o_dataRotatedI), 0);
      chk("reset_q", int'(o_dataRotatedQ), 0);
      chk("reset_sat", int'(o_sat), 0);
      chk("reset_cnt", int'(o_satCount), 0);
    end else if (last_kind == 2) begin
      if (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_valid", int'(o_valid), 1);
        chk("out_i", int'($signed(o_dataRotatedI)), e.ri);
        chk("out_q", int'($signed(o_dataRotatedQ)), e.rq);
        chk("out_sat", int'(o_sat), int'(e.sat));
`ifdef ROT_SAT_COUNT_EN
        if (e.sat && model_cnt < (1 << CW) - 1) model_cnt++;
`endif
      end else begin
        chk("idle_valid", int'(o_valid), 0);
        chk("idle_sat", int'(o_sat), 0);
      end
      chk("sat_count", int'(o_satCount), model_cnt);
    end else if (last_kind == 3) begin
      chk("hold_valid", int'(o_valid), int'(pv_valid));
      chk("hold_i", int'(o_dataRotatedI), int'(pv_i));
      chk("hold_q", int'(o_dataRotatedQ), int'(pv_q));
      chk("hold_sat", int'(o_sat), int'(pv_sat));
      chk("hold_cnt", int'(o_satCount), int'(pv_cnt));
    end
    pv_valid = o_valid;
    pv_i     = o_dataRotatedI;
    pv_q     = o_dataRotatedQ;
    pv_sat   = o_sat;
    pv_cnt   = o_satCount;
  end

  task automatic drive(input int i, input int q, input int s, input int c, input bit conj,
                       input bit v);
    i_dataI   = DW'(i);
    i_dataQ   = DW'(q);
    i_dataSin = DW'(s);
    i_dataCos = DW'(c);
    i_conj    = conj;
    i_valid   = v;
  endtask

  // One isolated sample; check DUT against literals three enabled edges later.
  task automatic one_shot(input string name, input int i, input int q, input int s, input int c,
                          input bit conj, input int ei, input int eq, input int es);
    @(posedge clock);
    #1 drive(i, q, s, c, conj, 1'b1);
    @(posedge clock);
    #1 drive(0, 0, 0, 0, 1'b0, 1'b0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk({name, "_valid"}, int'(o_valid), 1);
    chk({name, "_i"}, int'($signed(o_dataRotatedI)), ei);
    chk({name, "_q"}, int'($signed(o_dataRotatedQ)), eq);
    chk({name, "_sat"}, int'(o_sat), es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int vec [6][5] = '{
    '{ 100,  -50,   90,   90, 0},
    '{ -77,   33,  -90,  100, 1},
    '{-128, -128, -128,  127, 1},
    '{ 127,  127,  127,  127, 0},
    '{   1,   -1,   64,   64, 0},
    '{ -64,  -64,  -64,  -64, 1}
  };

  initial begin
    exp_t m;
    i_reset  = 1'b1;
    i_enable = 1'b1;
    drive(0, 0, 0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1 i_reset = 1'b0;

    m = rot(64, 0, 127, 0, 1'b1);
    chk("pin_rot90_conj_i", m.ri, 0);
    chk("pin_rot90_conj_q", m.rq, -63);
    m = rot(127, -128, 127, 127, 1'b0);
    chk("pin_possat_i", m.ri, 127);
    chk("pin_possat_q", m.rq, -1);
    m = rot(-128, -128, -128, 127, 1'b0);
    chk("pin_negsat_i", m.ri, -128);
    chk("pin_negsat_sat", int'(m.sat), 1);

    one_shot("identity", 64, 0, 0, 127, 1'b0, 64, 0, 0);
    one_shot("rot90_fwd", 64, 0, 127, 0, 1'b0, 0, 64, 0);
    one_shot("rot90_inv", 64, 0, 127, 0, 1'b1, 0, -63, 0);
    one_shot("pos_sat", 127, -128, 127, 127, 1'b0, 127, -1, 1);
    one_shot("neg_sat", -128, -128, -128, 127, 1'b0, -128, 1, 1);

    @(posedge clock);
    for (int k = 0; k < 6; k++) begin
      #1 drive(vec[k][0], vec[k][1], vec[k][2], vec[k][3], vec[k][4] != 0, 1'b1);
      @(posedge clock);
    end
    #1 drive(0, 0, 0, 0, 1'b0, 1'b0);
    repeat (4) @(posedge clock);

    // Stall after the second of four samples; junk offered while stalled.
    #1 drive(50, 20, 30, 120, 1'b0, 1'b1);
    @(posedge clock);
    #1 drive(-40, 90, -100, 60, 1'b1, 1'b1);
    @(posedge clock);
    #1 begin i_enable = 1'b0; drive(111, 111, 111, 111, 1'b0, 1'b1); end
    repeat (5) @(posedge clock);
    #1 begin i_enable = 1'b1; drive(127, 127, -128, -128, 1'b1, 1'b1); end
    @(posedge clock);
    #1 drive(-1, 2, 3, -4, 1'b0, 1'b1);
    @(posedge clock);
    #1 drive(0, 0, 0, 0, 1'b0, 1'b0);
    repeat (5) @(posedge clock);

    // Reset with samples in flight; nothing stale may emerge afterwards.
    #1 drive(127, -128, 127, 127, 1'b0, 1'b1);
    @(posedge clock);
    #1 drive(10, 20, 30, 40, 1'b1, 1'b1);
    @(posedge clock);
    #1 drive(-128, -128, -128, 127, 1'b0, 1'b1);
    @(posedge clock);
    #1 begin i_reset = 1'b1; drive(5, 5, 5, 5, 1'b0, 1'b1); end
    @(posedge clock);
    #1 begin i_reset = 1'b0; drive(0, 0, 0, 0, 1'b0, 1'b0); end
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
